// File: rtl/uart_tx_frame.sv
// UART transmit framer: accepts a byte over valid/ready, enables the baud
// generator and serialises start / data (LSB first) / parity / stop bits.
module uart_tx_frame #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY_EN  = 0,
   parameter int unsigned PARITY_ODD = 0,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic                 baud_tick,
   output logic                 baud_en,
   output logic                 txd,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int unsigned CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               r_state,    w_state;
   logic [DATA_BITS-1:0] r_shift,    w_shift;
   logic [CNT_W-1:0]     r_bit_cnt,  w_bit_cnt;
   logic                 r_stop_cnt, w_stop_cnt;
   logic                 r_parity,   w_parity;
   logic                 r_txd,      w_txd;
   logic                 r_tx_ready, w_tx_ready;
   logic                 r_baud_en,  w_baud_en;
   logic                 r_tx_busy,  w_tx_busy;
   logic                 r_tx_done,  w_tx_done;

   // State and registered outputs; reset drops txd high immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_parity   <= 1'b0;
         r_txd      <= 1'b1;
         r_tx_ready <= 1'b1;
         r_baud_en  <= 1'b0;
         r_tx_busy  <= 1'b0;
         r_tx_done  <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_shift    <= w_shift;
         r_bit_cnt  <= w_bit_cnt;
         r_stop_cnt <= w_stop_cnt;
         r_parity   <= w_parity;
         r_txd      <= w_txd;
         r_tx_ready <= w_tx_ready;
         r_baud_en  <= w_baud_en;
         r_tx_busy  <= w_tx_busy;
         r_tx_done  <= w_tx_done;
      end
   end

   // Next-state and next-output logic; the parity bit accumulates each data
   // bit as it is put on the line, so it is complete when the last one leaves
   always_comb begin
      w_state    = r_state;
      w_shift    = r_shift;
      w_bit_cnt  = r_bit_cnt;
      w_stop_cnt = r_stop_cnt;
      w_parity   = r_parity;
      w_txd      = r_txd;
      w_tx_ready = r_tx_ready;
      w_baud_en  = r_baud_en;
      w_tx_busy  = r_tx_busy;
      w_tx_done  = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_txd = 1'b1;
            if (tx_valid && r_tx_ready) begin
               w_state    = S_START;
               w_shift    = tx_data;
               w_bit_cnt  = '0;
               w_stop_cnt = 1'b0;
               w_parity   = 1'b0;
               w_txd      = 1'b0;
               w_baud_en  = 1'b1;
               w_tx_busy  = 1'b1;
               w_tx_ready = 1'b0;
            end
         end

         S_START: begin
            if (baud_tick) begin
               w_state  = S_DATA;
               w_txd    = r_shift[0];
               w_parity = r_shift[0];
            end
         end

         S_DATA: begin
            if (baud_tick) begin
               if (r_bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                  w_stop_cnt = 1'b0;
                  if (PARITY_EN != 0) begin
                     w_state = S_PARITY;
                     w_txd   = r_parity ^ 1'(PARITY_ODD);
                  end else begin
                     w_state = S_STOP;
                     w_txd   = 1'b1;
                  end
               end else begin
                  w_shift   = {1'b0, r_shift[DATA_BITS-1:1]};
                  w_bit_cnt = r_bit_cnt + CNT_W'(1);
                  w_txd     = r_shift[1];
                  w_parity  = r_parity ^ r_shift[1];
               end
            end
         end

         S_PARITY: begin
            if (baud_tick) begin
               w_state = S_STOP;
               w_txd   = 1'b1;
            end
         end

         S_STOP: begin
            w_txd = 1'b1;
            if (baud_tick) begin
               if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                  w_state    = S_IDLE;
                  w_tx_done  = 1'b1;
                  w_baud_en  = 1'b0;
                  w_tx_busy  = 1'b0;
                  w_tx_ready = 1'b1;
               end else begin
                  w_stop_cnt = r_stop_cnt + 1'b1;
               end
            end
         end

         default: begin
            w_state = S_IDLE;
            w_txd   = 1'b1;
         end
      endcase
   end

   assign tx_ready = r_tx_ready;
   assign baud_en  = r_baud_en;
   assign txd      = r_txd;
   assign tx_busy  = r_tx_busy;
   assign tx_done  = r_tx_done;

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmit framer directly downstream of the baud-rate generator (BuadRate_set).
- Accepts parallel bytes over a valid/ready handshake and drives `baud_en` to the generator's `enable` input.
- Consumes the generator's `Buad_clk` strobe to serialise each byte as start / data (LSB first) / optional parity / stop bits onto `txd`.
- Sits between the system-side byte source and the physical TX pin.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..8.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, with PARITY_EN=1: 0 selects even parity, 1 selects odd parity.
- STOP_BITS, 1, number of stop bits; legal 1 or 2.

Ports:
- clk  input  1  system clock, same clock as the baud generator.
- rst_n  input  1  asynchronous active-low reset.
- tx_data  input  DATA_BITS  byte to send; sampled only on handshake.
- tx_valid  input  1  source holds a byte.
- tx_ready  output  1  framer can accept a byte.
- baud_tick  input  1  one-clk-wide strobe, one per bit period; connects to generator `Buad_clk`.
- baud_en  output  1  enable to the generator; high while a frame is in flight.
- txd  output  1  serial line; idle high.
- tx_busy  output  1  frame in progress.
- tx_done  output  1  one-clk pulse at the end of the last stop bit.

Behaviour:
- Reset (asynchronous, rst_n=0) forces:
  - state=IDLE, txd=1, tx_ready=1, baud_en=0, tx_busy=0, tx_done=0.
  - Shift register, bit counter and parity accumulator cleared.
  - Reset mid-frame aborts immediately: txd returns high in the same cycle, and the partial frame is lost.
- Handshake:
  - Transfer occurs on a rising edge where tx_valid & tx_ready.
  - tx_ready = (state==IDLE); it is a registered output.
  - tx_data is captured into the shift register on the transfer edge; later changes to tx_data are ignored.
- Generator interface contract:
  - The generator restarts its divider when enable rises.
  - Its first tick arrives one bit period after baud_en rises, then one tick per bit period.
- States and transitions (all outputs registered):
  - IDLE: txd=1. On transfer, go to START and in the same edge set txd=0, baud_en=1, tx_busy=1, tx_ready=0, bit_cnt=0.
  - START: on baud_tick go to DATA and drive txd=shift[0].
  - DATA: on each baud_tick, shift right and increment bit_cnt.
    - When bit_cnt reaches DATA_BITS-1 on the tick, go to PARITY if PARITY_EN, else STOP.
    - Drive txd=1 for STOP, or the parity bit for PARITY.
  - PARITY: txd = XOR of the data bits XOR PARITY_ODD. On baud_tick, go to STOP with txd=1.
  - STOP: txd=1 for STOP_BITS ticks. On the final tick go to IDLE with tx_done=1 for one cycle, baud_en=0, tx_busy=0, tx_ready=1.
- baud_tick outside START/DATA/PARITY/STOP is ignored.
- Frame length: exactly 1+DATA_BITS+PARITY_EN+STOP_BITS bit periods, measured from the handshake edge.
- Back-to-back frames:
  - tx_ready rises in the same cycle as tx_done.
  - A transfer on the next edge starts a new frame. baud_en drops for exactly one cycle, re-arming the generator.
  - No gap beyond that one clk.
- txd only changes on the handshake edge, on a baud_tick edge, or on reset; it is glitch-free.
- tx_valid asserted while busy holds; tx_data must stay stable until accepted (source rule).

Test Plan:
- Reset / idle: hold rst_n=0 for 3 clks, release -> txd=1, tx_ready=1, baud_en=0, tx_done=0. No change with tx_valid=0 over 200 clks.
- Single byte, 8N1: bench tick every 16 clks, send 0xA5 -> txd sequence 0,1,0,1,0,0,1,0,1,1 (one bit per tick). tx_done pulses once, 160 clks after the handshake.
- Parity: PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit=1. With PARITY_ODD=1 -> parity bit=0. Frame is 11 bits.
- Back-to-back: tx_valid held high with 0x55 then 0xFF, STOP_BITS=2 -> second start bit begins 1 clk after the first tx_done. baud_en is low for exactly 1 clk between frames.
- Reset mid-frame: assert rst_n=0 during data bit 3 of 0x00 -> txd=1 asynchronously. After release: IDLE, tx_ready=1, no tx_done.
- Spurious ticks: pulse baud_tick while IDLE -> txd stays 1 and the state is unchanged.
